// File: rtl/video_timing_pkg.sv
// Shared SVGA 800x600@60 raster constants, stage payload type and colour expansion.
package video_timing_pkg;

    localparam int unsigned SVGA_H_ACT  = 800;
    localparam int unsigned SVGA_H_FP   = 40;
    localparam int unsigned SVGA_H_SYNC = 128;
    localparam int unsigned SVGA_H_BP   = 88;
    localparam int unsigned SVGA_V_ACT  = 600;
    localparam int unsigned SVGA_V_FP   = 1;
    localparam int unsigned SVGA_V_SYNC = 4;
    localparam int unsigned SVGA_V_BP   = 23;

    localparam int unsigned H_TOTAL = SVGA_H_ACT + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
    localparam int unsigned V_TOTAL = SVGA_V_ACT + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned RGB_W  = 24;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_t;

    // 3-bit RGB code to 24-bit {R,G,B}, each channel fully on or off
    function automatic logic [RGB_W-1:0] rgb_expand(input logic [2:0] code);
        return {{8{code[2]}}, {8{code[1]}}, {8{code[0]}}};
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with the raw (stage-0) sync, data-enable and frame decode.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACT   = SVGA_H_ACT,
    parameter int unsigned H_FP    = SVGA_H_FP,
    parameter int unsigned H_SYNC  = SVGA_H_SYNC,
    parameter int unsigned H_BP    = SVGA_H_BP,
    parameter int unsigned V_ACT   = SVGA_V_ACT,
    parameter int unsigned V_FP    = SVGA_V_FP,
    parameter int unsigned V_SYNC  = SVGA_V_SYNC,
    parameter int unsigned V_BP    = SVGA_V_BP,
    localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP,
    localparam int unsigned H_W    = $clog2(H_TOT),
    localparam int unsigned V_W    = $clog2(V_TOT)
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] o_h,
    output logic [V_W-1:0] o_v,
    output sync_t          o_raw
);

    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;
    logic           w_h_wrap;
    logic           w_v_wrap;

    assign w_h_wrap = (r_h == H_W'(H_TOT - 1));
    assign w_v_wrap = (r_v == V_W'(V_TOT - 1));

    // v advances only on the last pixel of a line; both wrap together at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_wrap ? '0 : r_h + H_W'(1);
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : r_v + V_W'(1);
            end
        end
    end

    always_comb begin
        o_raw    = '0;
        o_raw.de = (r_h < H_W'(H_ACT)) && (r_v < V_W'(V_ACT));
        o_raw.hs = (r_h >= H_W'(H_ACT + H_FP)) && (r_h < H_W'(H_ACT + H_FP + H_SYNC));
        o_raw.vs = (r_v >= V_W'(V_ACT + V_FP)) && (r_v < V_W'(V_ACT + V_FP + V_SYNC));
        o_raw.fs = (r_h == '0) && (r_v == '0);
    end

    assign o_h = r_h;
    assign o_v = r_v;

endmodule

// File: rtl/video_scanout.sv
// Character-cell scanout: cell address generation plus a 2-stage pipeline aligning
// sync/enable with colour returned by a 1-cycle-latency video memory.
module video_scanout
    import video_timing_pkg::*;
#(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned COLS    = 100,
    parameter int unsigned ROWS    = 75,
    parameter int unsigned CELL    = 8,
    parameter int unsigned H_ACT   = SVGA_H_ACT,
    parameter int unsigned H_FP    = SVGA_H_FP,
    parameter int unsigned H_SYNC  = SVGA_H_SYNC,
    parameter int unsigned H_BP    = SVGA_H_BP,
    parameter int unsigned V_ACT   = SVGA_V_ACT,
    parameter int unsigned V_FP    = SVGA_V_FP,
    parameter int unsigned V_SYNC  = SVGA_V_SYNC,
    parameter int unsigned V_BP    = SVGA_V_BP,
    localparam int unsigned H_W    = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
    localparam int unsigned V_W    = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rd_addr_x,
    output logic [ADDR_W-1:0] rd_addr_y,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_start
);

    localparam int unsigned CELL_SH   = $clog2(CELL);
    localparam bit          CELL_POW2 = (CELL == (32'd1 << CELL_SH));

    logic [H_W-1:0]   w_h;
    logic [V_W-1:0]   w_v;
    sync_t            w_raw;
    logic [H_W-1:0]   w_cx;
    logic [V_W-1:0]   w_cy;
    logic             w_in_grid;
    logic             w_unused_data;
    sync_t            r_s1;
    sync_t            r_s2;
    logic [RGB_W-1:0] r_rgb;

    video_timing_gen #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .o_h   (w_h),
        .o_v   (w_v),
        .o_raw (w_raw)
    );

    generate
        if (CELL_POW2) begin : g_shift
            assign w_cx = w_h >> CELL_SH;
            assign w_cy = w_v >> CELL_SH;
        end else begin : g_div
            assign w_cx = w_h / H_W'(CELL);
            assign w_cy = w_v / V_W'(CELL);
        end
    endgenerate

    // Grid bound keeps the read port inside the cell array even for odd geometries
    assign w_in_grid = w_raw.de && (32'(w_cx) < COLS) && (32'(w_cy) < ROWS);
    assign rd_addr_x = w_in_grid ? ADDR_W'(w_cx) : '0;
    assign rd_addr_y = w_in_grid ? ADDR_W'(w_cy) : '0;

    // Colour codes wider than 3 bits carry no meaning here
    assign w_unused_data = ^rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_rgb <= '0;
        end else begin
            r_s1  <= w_raw;
            r_s2  <= r_s1;
            r_rgb <= r_s1.de ? rgb_expand(rd_data[2:0]) : '0;
        end
    end

    assign hsync       = r_s2.hs;
    assign vsync       = r_s2.vs;
    assign de          = r_s2.de;
    assign frame_start = r_s2.fs;
    assign rgb         = r_rgb;

endmodule

// File: tb/tb_video_scanout.sv
// Scoreboarded bench: a scaled-raster instance checked cycle by cycle against a
// coordinate model, plus a default SVGA instance checked over its first line.
module tb_video_scanout;

    localparam int unsigned HA = 64, HF = 4, HS = 8, HB = 6;
    localparam int unsigned VA = 32, VF = 1, VS = 4, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned CSZ = 8;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  ax, ay;
    logic [2:0]  rdata;
    logic        hs, vs, de, fs;
    logic [23:0] rgb;

    logic [6:0]  d_ax, d_ay;
    logic [3:0]  d_rdata = 4'b1010;
    logic        d_hs, d_vs, d_de, d_fs;
    logic [23:0] d_rgb;

    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;
    exp_t sb_q[$];

    int eh, ev;
    int run, run_ax;
    bit stats_on = 0;
    int n_fs, n_de, n_hs, n_vs, hs_w, vs_w, max_ax, max_ay;
    logic hs_prev = 1'b0, vs_prev = 1'b0;

    bit d_on = 0;
    int d_cyc, d_fall, d_hs_rise, d_de_rise, d_max_ax;
    logic d_de_prev = 1'b0, d_hs_prev = 1'b0;

    always #5 clk = ~clk;

    video_scanout #(
        .WIDTH(3), .COLS(8), .ROWS(4), .CELL(CSZ),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
        .clk(clk), .rst(rst), .rd_addr_x(ax), .rd_addr_y(ay), .rd_data(rdata),
        .hsync(hs), .vsync(vs), .de(de), .rgb(rgb), .frame_start(fs)
    );

    video_scanout #(.WIDTH(4)) u_dut_svga (
        .clk(clk), .rst(rst), .rd_addr_x(d_ax), .rd_addr_y(d_ay), .rd_data(d_rdata),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .rgb(d_rgb), .frame_start(d_fs)
    );

    // Video memory: 1-cycle read latency, only cell (3,2) non-zero in pattern mode
    always @(posedge clk)
        rdata <= (mode == 1) ? 3'b111 : ((ax == 7'd3 && ay == 7'd2) ? 3'b101 : 3'b000);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hs), 32'd0);
        chk({tag, "_vsync"}, 32'(vs), 32'd0);
        chk({tag, "_de"},    32'(de), 32'd0);
        chk({tag, "_fs"},    32'(fs), 32'd0);
        chk({tag, "_rgb"},   32'(rgb), 32'd0);
        chk({tag, "_ax"},    32'(ax), 32'd0);
        chk({tag, "_ay"},    32'(ay), 32'd0);
        chk({tag, "_svga_de"},  32'(d_de), 32'd0);
        chk({tag, "_svga_rgb"}, 32'(d_rgb), 32'd0);
        chk({tag, "_svga_ax"},  32'(d_ax), 32'd0);
    endtask

    // Called just after rst falls: model restarts at (0,0), pipeline holds zeros
    task automatic release_model();
        sb_q.delete();
        sb_q.push_back('0);
        sb_q.push_back('0);
        eh  = 0;
        ev  = 0;
        run = 0;
    endtask

    task automatic step();
        exp_t e, o, p;
        int   ex_ax, ex_ay;
        @(negedge clk);
        e    = '0;
        e.de = (eh < HA) && (ev < VA);
        e.hs = (eh >= HA + HF) && (eh < HA + HF + HS);
        e.vs = (ev >= VA + VF) && (ev < VA + VF + VS);
        e.fs = (eh == 0) && (ev == 0);
        if (e.de && mode == 1)                           e.rgb = 24'hFFFFFF;
        else if (e.de && eh / CSZ == 3 && ev / CSZ == 2) e.rgb = 24'hFF00FF;
        ex_ax = e.de ? eh / CSZ : 0;
        ex_ay = e.de ? ev / CSZ : 0;
        chk("addr_x", 32'(ax), 32'(ex_ax));
        chk("addr_y", 32'(ay), 32'(ex_ay));

        sb_q.push_back(e);
        if (sb_q.size() > 2) begin
            p = sb_q.pop_front();
            o = {hs, vs, de, fs, rgb};
            chk("pixel", 32'(o), 32'(p));
        end

        if (e.de && run > 0 && 32'(ax) == run_ax) run++;
        else begin
            if (run > 0) chk("addr_hold", 32'(run), 32'(CSZ));
            run    = e.de ? 1 : 0;
            run_ax = 32'(ax);
        end

        if (stats_on) begin
            if (fs) n_fs++;
            if (de) n_de++;
            if (hs && !hs_prev) n_hs++;
            if (vs && !vs_prev) n_vs++;
            if (hs) hs_w++;
            else if (hs_prev) begin chk("hs_width", 32'(hs_w), 32'(HS)); hs_w = 0; end
            if (vs) vs_w++;
            else if (vs_prev) begin chk("vs_width", 32'(vs_w), 32'(VS * HT)); vs_w = 0; end
            if (32'(ax) > max_ax) max_ax = 32'(ax);
            if (32'(ay) > max_ay) max_ay = 32'(ay);
        end
        hs_prev = hs;
        vs_prev = vs;

        if (d_on) begin
            d_cyc++;
            chk("svga_rgb", 32'(d_rgb), d_de ? 32'h00FF00 : 32'h0);
            if (d_de_prev && !d_de && d_fall < 0) d_fall = d_cyc;
            if (d_fall >= 0 && d_hs && !d_hs_prev && d_hs_rise < 0) d_hs_rise = d_cyc;
            if (d_fall >= 0 && d_de && !d_de_prev && d_de_rise < 0) d_de_rise = d_cyc;
            if (32'(d_ax) > d_max_ax) d_max_ax = 32'(d_ax);
            d_de_prev = d_de;
            d_hs_prev = d_hs;
            if (d_cyc == 1200) begin
                chk("svga_hs_after_de_fall", 32'(d_hs_rise - d_fall), 32'd40);
                chk("svga_de_blank_len",     32'(d_de_rise - d_fall), 32'd256);
                chk("svga_max_addr_x",       32'(d_max_ax), 32'd99);
                d_on = 0;
            end
        end

        eh++;
        if (eh == HT) begin
            eh = 0;
            ev++;
            if (ev == VT) ev = 0;
        end
    endtask

    task automatic fs_after_release(input string tag);
        step(); chk({tag, "_fs_c0"}, 32'(fs), 32'd0);
        step(); chk({tag, "_fs_c1"}, 32'(fs), 32'd0);
        step(); chk({tag, "_fs_c2"}, 32'(fs), 32'd1);
        step(); chk({tag, "_fs_c3"}, 32'(fs), 32'd0);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");

        // Frame 1: cell pattern, full-frame statistics, then the frame wrap
        rst = 1'b0;
        release_model();
        d_on = 1; d_cyc = 0; d_fall = -1; d_hs_rise = -1; d_de_rise = -1; d_max_ax = 0;
        step();
        step();
        n_fs = 0; n_de = 0; n_hs = 0; n_vs = 0; hs_w = 0; vs_w = 0; max_ax = 0; max_ay = 0;
        stats_on = 1;
        repeat (HT * VT) step();
        stats_on = 0;
        chk("frame_fs_count",  32'(n_fs), 32'd1);
        chk("frame_de_count",  32'(n_de), 32'(HA * VA));
        chk("frame_hs_pulses", 32'(n_hs), 32'(VT));
        chk("frame_vs_pulses", 32'(n_vs), 32'd1);
        chk("frame_max_ax",    32'(max_ax), 32'd7);
        chk("frame_max_ay",    32'(max_ay), 32'd3);
        step();
        chk("fs_after_wrap", 32'(fs), 32'd1);
        chk("de_after_wrap", 32'(de), 32'd1);

        // Asynchronous reset between edges, switch memory to constant white
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async1");
        mode = 1;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("held1");
        rst = 1'b0;
        release_model();
        fs_after_release("rel1");

        // Run to mid-frame, then pulse reset for 3 cycles
        guard = 0;
        while (!(eh == HA / 2 && ev == VA / 2) && guard < int'(HT * VT)) begin
            step();
            guard++;
        end
        chk("reach_mid_frame", 32'(guard < int'(HT * VT)), 32'd1);
        @(posedge clk);
        #2;
        chk("mid_pre_de",  32'(de), 32'd1);
        chk("mid_pre_rgb", 32'(rgb), 32'hFFFFFF);
        rst = 1'b1;
        #1 chk_reset_outputs("async2");
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("held2");
        rst = 1'b0;
        release_model();
        fs_after_release("rel2");

        // Constant white over a full frame: colour only while de
        repeat (HT * VT) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
